// File: rtl/branch_resolve_queue_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_pkg
//
// Shared definitions for the branch resolve queue.
//   WIDTH_PATERN_LENGTH : default global history register width
//   BRQ_DEPTH_DEFAULT   : default number of in-flight branch entries
//   brq_entry_t         : one queued branch, {pred_bit, ghr}
//   brq_ptr_w()         : pointer width for a given queue depth
// -----------------------------------------------------------------------------
package branch_resolve_queue_pkg;

   localparam int WIDTH_PATERN_LENGTH = 3;
   localparam int BRQ_DEPTH_DEFAULT   = 4;

   typedef struct packed {
      logic                           pred_bit;
      logic [WIDTH_PATERN_LENGTH-1:0] ghr;
   } brq_entry_t;

   // A depth of 1 would give a zero-width pointer; keep at least one bit.
   function automatic int brq_ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/brq_entry_fifo.sv
// -----------------------------------------------------------------------------
// brq_entry_fifo
//
// Circular entry store for the branch resolve queue. Holds predicted branches
// in program order; head is the oldest, tail the next free slot. Pointers
// wrap modulo DEPTH (power of two, so natural binary overflow does the wrap).
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset (pointers and count only)
//   push     : write wr_data at tail (caller guarantees room, or a same-cycle pop)
//   pop      : retire the head entry
//   flush    : discard every entry; wins over push and pop
//   wr_data  : entry to write
//   rd_data  : entry at head (valid whenever empty is 0)
//   count    : number of live entries, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// -----------------------------------------------------------------------------
module brq_entry_fifo
   import branch_resolve_queue_pkg::*;
#(
   parameter  int DEPTH   = BRQ_DEPTH_DEFAULT,
   parameter  int ENTRY_W = WIDTH_PATERN_LENGTH + 1,
   localparam int PTR_W   = brq_ptr_w(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [ENTRY_W-1:0] rd_data,
   output logic [PTR_W:0]     count,
   output logic               full,
   output logic               empty
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;

   // Control state: pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         // Collapse the queue onto the current tail; any same-cycle push is lost.
         head  <= tail;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset; stale slots are unreachable once the
   // pointers are cleared.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[tail] <= wr_data;
   end

   assign rd_data = mem[head];
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Tracks predicted branches between fetch and execute. Fetch pushes
// {Pred_Bit, Pred_GHR}; execute resolves the oldest entry. Each resolve
// produces a one-cycle-late predictor update strobe; a wrong prediction
// raises a one-cycle Mispredict pulse, flushes the queue and publishes the
// corrected global history on Restore_GHR.
//
// Optional feature: define BRQ_MISPREDICT_STATS_EN to add a 16-bit saturating
// mispredict counter on output Mispredict_Cnt.
//
// Parameters
//   DEPTH               : in-flight entries (power of two, >= 2)
//   WIDTH_PATERN_LENGTH : global history register width
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : synchronous active-low reset
//   Stall_Detected : pipeline stall; freezes the queue, suppresses strobes
//   Pred_Valid     : push request from fetch
//   Pred_Bit       : predicted direction (1 = taken)
//   Pred_GHR       : history snapshot used for the prediction
//   Res_Valid      : execute resolves the oldest branch
//   Res_Taken      : actual direction
//   Br_Detected    : predictor update strobe (cycle after a resolve)
//   Br_Comp_Result : resolved direction for the predictor update
//   Mispredict     : one-cycle flush pulse
//   Restore_GHR    : corrected history, held until the next mispredict
//   Full / Empty   : occupancy flags decoded from Count
//   Count          : live entries
//   Underflow_Err  : sticky, set by a resolve on an empty queue
//   Mispredict_Cnt : (BRQ_MISPREDICT_STATS_EN only) saturating pulse counter
// -----------------------------------------------------------------------------
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter  int DEPTH               = BRQ_DEPTH_DEFAULT,
   parameter  int WIDTH_PATERN_LENGTH = branch_resolve_queue_pkg::WIDTH_PATERN_LENGTH,
   localparam int CNT_W               = brq_ptr_w(DEPTH) + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           Stall_Detected,
   input  logic                           Pred_Valid,
   input  logic                           Pred_Bit,
   input  logic [WIDTH_PATERN_LENGTH-1:0] Pred_GHR,
   input  logic                           Res_Valid,
   input  logic                           Res_Taken,
   output logic                           Br_Detected,
   output logic                           Br_Comp_Result,
   output logic                           Mispredict,
   output logic [WIDTH_PATERN_LENGTH-1:0] Restore_GHR,
   output logic                           Full,
   output logic                           Empty,
   output logic [CNT_W-1:0]               Count,
   output logic                           Underflow_Err
`ifdef BRQ_MISPREDICT_STATS_EN
   ,
   output logic [15:0]                    Mispredict_Cnt
`endif
);

   localparam int GW      = WIDTH_PATERN_LENGTH;
   localparam int ENTRY_W = GW + 1;

   // Stage p0: decode push/pop/compare against the head entry.
   logic               pop_p0;
   logic               push_p0;
   logic               mispred_p0;
   logic               underflow_p0;
   logic [ENTRY_W-1:0] head_entry_p0;
   logic               head_pred_p0;
   logic [GW-1:0]      head_ghr_p0;
   logic [GW:0]        shifted_hist_p0;
   logic [GW-1:0]      restore_p0;
   logic               fifo_full;
   logic               fifo_empty;

   assign head_pred_p0 = head_entry_p0[GW];
   assign head_ghr_p0  = head_entry_p0[GW-1:0];

   assign pop_p0       = Res_Valid && !Stall_Detected && !fifo_empty;
   // A full queue still accepts a push when the head retires in the same cycle.
   assign push_p0      = Pred_Valid && !Stall_Detected && (!fifo_full || pop_p0);
   assign mispred_p0   = pop_p0 && (head_pred_p0 != Res_Taken);
   assign underflow_p0 = Res_Valid && !Stall_Detected && fifo_empty;

   // Corrected history: actual outcome shifted in at the MSB, oldest bit dropped.
   assign shifted_hist_p0 = {Res_Taken, head_ghr_p0};
   assign restore_p0      = shifted_hist_p0[GW:1];

   brq_entry_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_p0),
      .pop     (pop_p0),
      .flush   (mispred_p0),
      .wr_data ({Pred_Bit, Pred_GHR}),
      .rd_data (head_entry_p0),
      .count   (Count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign Full  = fifo_full;
   assign Empty = fifo_empty;

   // Stage p1: registered predictor update and flush outputs.
   logic          vld_p1;
   logic          taken_p1;
   logic          mispred_p1;
   logic [GW-1:0] restore_p1;
   logic          underflow_p1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         taken_p1     <= 1'b0;
         mispred_p1   <= 1'b0;
         restore_p1   <= '0;
         underflow_p1 <= 1'b0;
      end else begin
         vld_p1     <= pop_p0;
         mispred_p1 <= mispred_p0;
         if (pop_p0)       taken_p1     <= Res_Taken;
         if (mispred_p0)   restore_p1   <= restore_p0;
         if (underflow_p0) underflow_p1 <= 1'b1;
      end
   end

   assign Br_Detected    = vld_p1;
   assign Br_Comp_Result = taken_p1;
   assign Mispredict     = mispred_p1;
   assign Restore_GHR    = restore_p1;
   assign Underflow_Err  = underflow_p1;

`ifdef BRQ_MISPREDICT_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Stage p2: count Mispredict pulses as they leave p1.
   logic [15:0] mispred_cnt_p2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mispred_cnt_p2 <= '0;
      end else if (mispred_p1) begin
         mispred_cnt_p2 <= sat_inc16(mispred_cnt_p2);
      end
   end

   assign Mispredict_Cnt = mispred_cnt_p2;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

   localparam int DEPTH = 4;
   localparam int W     = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         stall;
   logic         pred_valid;
   logic         pred_bit;
   logic [W-1:0] pred_ghr;
   logic         res_valid;
   logic         res_taken;
   logic         br_detected;
   logic         br_comp_result;
   logic         mispredict;
   logic [W-1:0] restore_ghr;
   logic         full;
   logic         empty;
   logic [2:0]   count;
   logic         underflow_err;

   always #5 clk = ~clk;

   branch_resolve_queue #(
      .DEPTH               (DEPTH),
      .WIDTH_PATERN_LENGTH (W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Stall_Detected (stall),
      .Pred_Valid     (pred_valid),
      .Pred_Bit       (pred_bit),
      .Pred_GHR       (pred_ghr),
      .Res_Valid      (res_valid),
      .Res_Taken      (res_taken),
      .Br_Detected    (br_detected),
      .Br_Comp_Result (br_comp_result),
      .Mispredict     (mispredict),
      .Restore_GHR    (restore_ghr),
      .Full           (full),
      .Empty          (empty),
      .Count          (count),
      .Underflow_Err  (underflow_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   // Reference model: an ordered list of in-flight branches plus the
   // expected registered outputs.
   logic [W:0]   q[$];
   logic         m_bd   = 1'b0;
   logic         m_bcr  = 1'b0;
   logic         m_misp = 1'b0;
   logic [W-1:0] m_rghr = '0;
   logic         m_uf   = 1'b0;

   task automatic step(input logic r, input logic s, input logic pv, input logic pb,
                       input logic [W-1:0] pg, input logic rv, input logic rt);
      bit         was_full;
      bit         was_empty;
      bit         do_pop;
      bit         do_push;
      logic [W:0] oldest;
      rst_n      = r;
      stall      = s;
      pred_valid = pv;
      pred_bit   = pb;
      pred_ghr   = pg;
      res_valid  = rv;
      res_taken  = rt;
      @(posedge clk);
      if (!r) begin
         q.delete();
         m_bd   = 1'b0;
         m_bcr  = 1'b0;
         m_misp = 1'b0;
         m_rghr = '0;
         m_uf   = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         do_pop    = rv && !s && !was_empty;
         do_push   = pv && !s && (!was_full || do_pop);
         m_bd      = do_pop;
         m_misp    = 1'b0;
         if (do_pop) begin
            oldest = q[0];
            m_bcr  = rt;
            if (oldest[W] != rt) begin
               m_misp = 1'b1;
               m_rghr = {rt, oldest[W-1:1]};
            end
         end
         if (rv && !s && was_empty) m_uf = 1'b1;
         if (m_misp) begin
            q.delete();
         end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back({pb, pg});
         end
      end
      #1;
      check("br_detected",    32'(br_detected),    32'(m_bd));
      check("br_comp_result", 32'(br_comp_result), 32'(m_bcr));
      check("mispredict",     32'(mispredict),     32'(m_misp));
      check("restore_ghr",    32'(restore_ghr),    32'(m_rghr));
      check("underflow_err",  32'(underflow_err),  32'(m_uf));
      check("count",          32'(count),          32'(q.size()));
      check("full",           32'(full),           32'(q.size() == DEPTH));
      check("empty",          32'(empty),          32'(q.size() == 0));
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset, including requests presented during reset.
      step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1'b1, 1'b1);
      idle();

      // Three correctly predicted taken branches.
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
      idle();

      // Single mispredict: restore history becomes 3'b111.
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
      check("restore_after_misp", 32'(restore_ghr), 32'h7);
      idle();
      idle();

      // Fill, overflow push, push+pop at full, then drain in order.
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
      idle();

      // Mispredict on the oldest of three with a same-cycle push.
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0);
      idle();

      // Resolve on empty, stall freeze, then reset mid-sequence.
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'b110, 1'b1, 1'b1);
      idle();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) != 0),
              ($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              W'($urandom_range(0, 7)),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
